// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one single-cycle-latency memory port.
// Optional burst-length fairness limit is enabled by defining ARB_BURST_LIMIT_EN.
module sha_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [16*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rd_valid,
  output logic [31:0]             rd_data,
  output logic                    busy,
  output logic                    mem_clk,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data
);

  localparam int                IDX_W    = $clog2(NUM_REQ);
  localparam logic [7:0]        MAX_B    = 8'(MAX_BURST);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] rd_valid_reg, rd_valid_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [7:0]         burst_reg, burst_next;

  logic [15:0]        addr_arr  [NUM_REQ];
  logic [31:0]        wdata_arr [NUM_REQ];
  logic               access;
  logic [7:0]         burst_inc;
  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               take;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[16*gi +: 16];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
    end
  endgenerate

  // An access issues whenever the registered owner keeps its request up.
  assign access         = (state_reg == OWN) && gnt_reg[owner_reg] && req[owner_reg];
  assign mem_clk        = clk;
  assign mem_we         = access & req_we[owner_reg];
  assign mem_addr       = access ? addr_arr[owner_reg]  : 16'h0000;
  assign mem_write_data = access ? wdata_arr[owner_reg] : 32'h0000_0000;

  assign gnt      = gnt_reg;
  assign busy     = |gnt_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = (|rd_valid_reg) ? mem_read_data : 32'h0000_0000;

  assign burst_inc = (access && (burst_reg != MAX_B)) ? burst_reg + 8'd1 : burst_reg;

  // Round-robin search from ptr_reg; the current owner never competes against itself.
  always_comb begin
    cand = req;
    if (state_reg == OWN) cand[owner_reg] = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand[IDX_W'((int'(ptr_reg) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    owner_next    = owner_reg;
    ptr_next      = ptr_reg;
    burst_next    = burst_inc;
    rd_valid_next = '0;
    take          = 1'b0;

    if (access && !req_we[owner_reg]) rd_valid_next[owner_reg] = 1'b1;

    case (state_reg)
      IDLE: take = win_found;
      OWN: begin
        if (!req[owner_reg]) begin
          take = win_found;
          if (!win_found) begin
            state_next = IDLE;
            gnt_next   = '0;
            burst_next = '0;
          end
        end
`ifdef ARB_BURST_LIMIT_EN
        else if (burst_inc == MAX_B) begin
          // Burst exhausted: yield to a waiting requester, or restart the count alone.
          take = win_found;
          if (!win_found) burst_next = '0;
        end
`endif
      end
      default: ;
    endcase

    if (take) begin
      state_next          = OWN;
      gnt_next            = '0;
      gnt_next[win_idx]   = 1'b1;
      owner_next          = win_idx;
      ptr_next            = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      burst_next          = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      rd_valid_reg <= '0;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      burst_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      rd_valid_reg <= rd_valid_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      burst_reg    <= burst_next;
    end
  end

endmodule
